// File: rtl/fb_sync_arbiter.sv
// fb_sync_arbiter: round-robin sharing of one handshake pulse synchronizer among NUM_REQ event sources
module fb_sync_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clkA,
    input  logic               resetA,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               sync_busy,
    output logic               sync_inA,
    output logic [ID_W-1:0]    sel_id,
    output logic [NUM_REQ-1:0] pend,
    output logic [NUM_REQ-1:0] done_pulse,
    output logic [NUM_REQ-1:0] drop_pulse,
    output logic               timeout_err
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, DONE} state_t;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [15:0]        TMO = 16'(TIMEOUT_CYC);
    state_t             state;
    logic [ID_W-1:0]    last;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    idx;
    logic               gnt_vld;
    logic               grant;
    logic [15:0]        cnt;
    logic [NUM_REQ-1:0] clr;

    // rotating priority search; the candidate closest after the last grant wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (pend[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign grant = (state == IDLE) && !sync_busy && gnt_vld;
    assign clr   = grant ? ONE << gnt_id : '0;

    // pending flags: a new event beats the grant clear, a repeat on a still-pending flag is dropped
    always_ff @(posedge clkA) begin
        if (resetA) begin
            pend       <= '0;
            drop_pulse <= '0;
        end else begin
            pend       <= (pend & ~clr) | req_pulse;
            drop_pulse <= req_pulse & pend & ~clr;
        end
    end

    // handshake sequencer with registered outputs and a watchdog over the wait states
    always_ff @(posedge clkA) begin
        if (resetA) begin
            state       <= IDLE;
            sync_inA    <= 1'b0;
            sel_id      <= '0;
            done_pulse  <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            last        <= ID_W'(NUM_REQ - 1);
        end else begin
            sync_inA   <= 1'b0;
            done_pulse <= '0;
            case (state)
                IDLE: if (grant) begin
                    state    <= LAUNCH;
                    sync_inA <= 1'b1;
                    sel_id   <= gnt_id;
                    last     <= gnt_id;
                    cnt      <= '0;
                end
                LAUNCH: state <= WAIT_HI;
                WAIT_HI, WAIT_LO: begin
                    cnt <= cnt + 16'd1;
                    if (cnt + 16'd1 == TMO) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else if (state == WAIT_HI && sync_busy) begin
                        state <= WAIT_LO;
                    end else if (state == WAIT_LO && !sync_busy) begin
                        state      <= DONE;
                        done_pulse <= ONE << sel_id;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
